sequential_divider_32: RTL and testbench



---
 rtl/sequential_divider_32.sv | 121 ++++++++++++
 tb/tb_sequential_divider_32.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider_32.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Signed operation divides magnitudes and fixes the signs in a final cycle.
module sequential_divider_32 #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(size) + 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t        state, state_next;
    logic [size:0]   r;
    logic [size-1:0] q;
    logic [size-1:0] mag_b;
    logic [CW-1:0]   count;
    logic            sign_q, sign_r;

    logic [size:0]   r_shift, r_sub, r_next;
    logic            ge;
    logic [size-1:0] mag_a_in, mag_b_in;

    // R stays below the divisor magnitude, so its carry bit is free before the shift.
    always_comb begin
        r_shift = {r[size-1:0], q[size-1]};
        r_sub   = r_shift - {1'b0, mag_b};
        ge      = (r_shift >= {1'b0, mag_b});
        r_next  = ge ? r_sub : r_shift;
    end

    always_comb begin
        mag_a_in = (is_signed && dividend[size-1]) ? -dividend : dividend;
        mag_b_in = (is_signed && divisor[size-1])  ? -divisor  : divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : DIV;
            DIV: begin
                busy = 1'b1;
                if (count == LAST) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            mag_b       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            r           <= '0;
                            q           <= mag_a_in;
                            mag_b       <= mag_b_in;
                            sign_q      <= is_signed & (dividend[size-1] ^ divisor[size-1]);
                            sign_r      <= is_signed & dividend[size-1];
                            count       <= '0;
                        end
                    end
                end
                DIV: begin
                    r     <= r_next;
                    q     <= {q[size-2:0], ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    quotient  <= sign_q ? -q : q;
                    remainder <= sign_r ? -r[size-1:0] : r[size-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider_32.sv
// Directed and randomised checks of sequential_divider_32 with an expected-result queue.
module tb_sequential_divider_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];

    sequential_divider_32 #(.size(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q = q;
        e.r = r;
        e.dbz = dbz;
        return e;
    endfunction

    // Reference behaviour from the language's own division operators.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (b == 32'd0) return mk(32'hFFFFFFFF, a, 1'b1);
        if (sgn) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return mk(32'h80000000, 32'd0, 1'b0);
            return mk(32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b)), 1'b0);
        end
        return mk(a / b, a % b, 1'b0);
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input exp_t e);
        int lat;
        int busy_cycles;
        int exp_lat;
        exp_t got;
        exp_lat = (b == 32'd0) ? 0 : 33;
        start = 1'b1;
        dividend = a;
        divisor = b;
        is_signed = sgn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        is_signed = ~sgn;
        if (exp_lat != 0) check({tag, " cleared at start"}, quotient, 32'd0);
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " done seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_cycles, exp_lat);
        check({tag, " busy low at done"}, 32'(busy), 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, " quotient"}, quotient, got.q);
            check({tag, " remainder"}, remainder, got.r);
            check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(got.dbz));
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done single pulse"}, 32'(done), 32'd0);
        check({tag, " start in DONE ignored"}, 32'(busy), 32'd0);
        check({tag, " quotient held"}, quotient, e.q);
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        logic rs;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("u100/7", 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0));
        run_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0));
        run_op("u-7/2", 32'hFFFFFFF9, 32'd2, 1'b0, mk(32'h7FFFFFFC, 32'd1, 1'b0));
        run_op("u/0", 32'h12345678, 32'd0, 1'b0, mk(32'hFFFFFFFF, 32'h12345678, 1'b1));
        run_op("s/0", 32'h12345678, 32'd0, 1'b1, mk(32'hFFFFFFFF, 32'h12345678, 1'b1));
        run_op("s ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, mk(32'h80000000, 32'd0, 1'b0));
        run_op("uFFFF/1", 32'hFFFFFFFF, 32'd1, 1'b0, mk(32'hFFFFFFFF, 32'd0, 1'b0));
        run_op("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, mk(32'hFFFFFFFD, 32'd1, 1'b0));

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd3;
            rs = 1'(i % 2);
            run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // Abort a division in flight: the mid-run start is ignored and reset wipes everything.
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd5;
        divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mid start ignored busy", 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort div_by_zero", 32'(div_by_zero), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk);
            #1;
        end
        check("no done after abort", done_seen, 0);
        run_op("after abort 5/5", 32'd5, 32'd5, 1'b0, mk(32'd1, 32'd0, 1'b0));

        // Reset and start together: the start must not be captured.
        rst = 1'b1;
        start = 1'b1;
        dividend = 32'd9;
        divisor = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check("rst+start done", 32'(done), 32'd0);
        check("rst+start dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        check("rst+start busy", 32'(busy), 32'd0);
        check("rst+start done later", 32'(done), 32'd0);

        // Mid-run start during a completed division must leave its result intact.
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        is_signed = 1'b0;
        sb.push_back(mk(32'd333, 32'd1, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 32'd5;
        divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("ignored start done", 32'(done), 32'd1);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ignored start quotient", quotient, e.q);
            check("ignored start remainder", remainder, e.r);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
